// File: rtl/crossbar_noc_pkg.sv
// Shared sizes and the slave-port state type for the 3x4 APB crossbar.
package crossbar_noc_pkg;
    localparam int NUM_MST  = 3;
    localparam int NUM_SLV  = 4;
    localparam int ADDR_W   = 62;
    localparam int DATA_W   = 32;
    localparam int SLV_ID_W = 2;
    localparam int OFFS_W   = 60;
    localparam int MST_ID_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } slv_state_e;
endpackage

// File: rtl/crossbar_noc_slv_port.sv
// One completer port: arrival-order queue of master IDs, APB slave-side FSM
// and a one-hot completion strobe pointing at the master being served.
module crossbar_noc_slv_port
    import crossbar_noc_pkg::*;
(
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic [NUM_MST-1:0]             req,
    input  logic [NUM_MST-1:0]             mst_write,
    input  logic [NUM_MST-1:0][OFFS_W-1:0] mst_offs,
    input  logic [NUM_MST-1:0][DATA_W-1:0] mst_wdata,
    input  logic                           pready,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [OFFS_W-1:0]              paddr,
    output logic [DATA_W-1:0]              pwdata,
    output logic [NUM_MST-1:0]             cpl
);
    slv_state_e          state;
    logic [MST_ID_W-1:0] q  [NUM_MST];
    logic [MST_ID_W-1:0] nq [NUM_MST];
    logic [MST_ID_W-1:0] cnt;
    logic [MST_ID_W-1:0] ncnt;
    logic [MST_ID_W-1:0] cur;
    logic                pop;
    logic                start;

    assign pop   = (state == ACCESS) && pready;
    // Arrivals of this cycle are visible to the launch decision so an
    // uncontended request reaches SETUP on the very next edge.
    assign start = ((state == IDLE) || pop) && (ncnt != '0);

    // The head entry stays queued while it is being served; pop drops it,
    // then same-cycle arrivals are appended lowest master ID first.
    always_comb begin
        nq   = q;
        ncnt = cnt;
        if (pop) begin
            for (int k = 0; k < NUM_MST - 1; k++) nq[k] = q[k+1];
            nq[NUM_MST-1] = '0;
            ncnt = cnt - 2'd1;
        end
        for (int i = 0; i < NUM_MST; i++) begin
            if (req[i]) begin
                nq[ncnt] = MST_ID_W'(i);
                ncnt     = ncnt + 2'd1;
            end
        end
    end

    always_comb begin
        cpl = '0;
        if (pop) cpl[cur] = 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur     <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            for (int k = 0; k < NUM_MST; k++) q[k] <= '0;
        end else begin
            q   <= nq;
            cnt <= ncnt;
            if (start) begin
                state   <= SETUP;
                cur     <= nq[0];
                psel    <= 1'b1;
                penable <= 1'b0;
                pwrite  <= mst_write[nq[0]];
                paddr   <= mst_offs[nq[0]];
                pwdata  <= mst_wdata[nq[0]];
            end else begin
                case (state)
                    SETUP: begin
                        state   <= ACCESS;
                        penable <= 1'b1;
                    end
                    ACCESS: begin
                        if (pop) begin
                            state   <= IDLE;
                            psel    <= 1'b0;
                            penable <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/crossbar_noc.sv
// 3-requester x 4-completer APB crossbar: request decode by the top address
// bits, one arbitrated port per completer, registered responses per master.
module crossbar_noc
    import crossbar_noc_pkg::*;
(
    input  logic                        pclk,
    input  logic                        preset_n,
    input  logic [NUM_MST-1:0]          m_psel,
    input  logic [NUM_MST-1:0]          m_penable,
    input  logic [NUM_MST-1:0]          m_pwrite,
    input  logic [NUM_MST*ADDR_W-1:0]   m_paddr,
    input  logic [NUM_MST*DATA_W-1:0]   m_pwdata,
    output logic [NUM_MST*DATA_W-1:0]   m_prdata,
    output logic [NUM_MST-1:0]          m_pready,
    output logic [NUM_MST-1:0]          m_pslverr,
    output logic [NUM_SLV-1:0]          s_psel,
    output logic [NUM_SLV-1:0]          s_penable,
    output logic [NUM_SLV-1:0]          s_pwrite,
    output logic [NUM_SLV*OFFS_W-1:0]   s_paddr,
    output logic [NUM_SLV*DATA_W-1:0]   s_pwdata,
    input  logic [NUM_SLV*DATA_W-1:0]   s_prdata,
    input  logic [NUM_SLV-1:0]          s_pready,
    input  logic [NUM_SLV-1:0]          s_pslverr
);
    logic [NUM_MST-1:0]               pending;
    logic [NUM_MST-1:0]               req;
    logic [NUM_MST-1:0][SLV_ID_W-1:0] tgt;
    logic [NUM_MST-1:0][OFFS_W-1:0]   offs;
    logic [NUM_MST-1:0][DATA_W-1:0]   wdata;
    logic [NUM_SLV-1:0][NUM_MST-1:0]  slv_req;
    logic [NUM_SLV-1:0][NUM_MST-1:0]  slv_cpl;
    logic [NUM_MST-1:0]               cpl;
    logic [NUM_MST-1:0]               cpl_err;
    logic [NUM_MST-1:0]               cpl_wr;
    logic [NUM_MST-1:0][DATA_W-1:0]   cpl_rdata;

    // A request is the setup phase of a master with nothing outstanding,
    // so a master lingering in setup is never queued twice.
    always_comb begin
        req     = '0;
        tgt     = '0;
        offs    = '0;
        wdata   = '0;
        slv_req = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            offs[i]  = m_paddr[i*ADDR_W +: OFFS_W];
            tgt[i]   = m_paddr[i*ADDR_W + OFFS_W +: SLV_ID_W];
            wdata[i] = m_pwdata[i*DATA_W +: DATA_W];
            req[i]   = m_psel[i] && !m_penable[i] && !pending[i];
            if (req[i]) slv_req[tgt[i]][i] = 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
        crossbar_noc_slv_port u_port (
            .pclk      (pclk),
            .preset_n  (preset_n),
            .req       (slv_req[s]),
            .mst_write (m_pwrite),
            .mst_offs  (offs),
            .mst_wdata (wdata),
            .pready    (s_pready[s]),
            .psel      (s_psel[s]),
            .penable   (s_penable[s]),
            .pwrite    (s_pwrite[s]),
            .paddr     (s_paddr[s*OFFS_W +: OFFS_W]),
            .pwdata    (s_pwdata[s*DATA_W +: DATA_W]),
            .cpl       (slv_cpl[s])
        );
    end

    always_comb begin
        cpl       = '0;
        cpl_err   = '0;
        cpl_wr    = '0;
        cpl_rdata = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (slv_cpl[s][i]) begin
                    cpl[i]       = 1'b1;
                    cpl_err[i]   = s_pslverr[s];
                    cpl_wr[i]    = s_pwrite[s];
                    cpl_rdata[i] = s_prdata[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            pending   <= '0;
            m_pready  <= '0;
            m_pslverr <= '0;
            m_prdata  <= '0;
        end else begin
            pending  <= (pending | req) & ~cpl;
            m_pready <= cpl;
            for (int i = 0; i < NUM_MST; i++) begin
                if (cpl[i]) begin
                    m_pslverr[i] <= cpl_err[i];
                    if (!cpl_wr[i]) m_prdata[i*DATA_W +: DATA_W] <= cpl_rdata[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_crossbar_noc.sv
// Directed bench for crossbar_noc: cycle-by-cycle master stimulus, slaves
// answer ready while rdy_en allows it, expectations computed by hand.
module tb_crossbar_noc;
    logic          pclk;
    logic          preset_n;
    logic [2:0]    m_psel;
    logic [2:0]    m_penable;
    logic [2:0]    m_pwrite;
    logic [185:0]  m_paddr;
    logic [95:0]   m_pwdata;
    logic [95:0]   m_prdata;
    logic [2:0]    m_pready;
    logic [2:0]    m_pslverr;
    logic [3:0]    s_psel;
    logic [3:0]    s_penable;
    logic [3:0]    s_pwrite;
    logic [239:0]  s_paddr;
    logic [127:0]  s_pwdata;
    logic [127:0]  s_prdata;
    logic [3:0]    s_pready;
    logic [3:0]    s_pslverr;
    logic [3:0]    rdy_en;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    crossbar_noc dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr)
    );

    assign s_pready = s_penable & rdy_en;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic next();
        @(posedge pclk);
        #1;
    endtask

    task automatic mid();
        @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic [1:0] slv, input logic wr,
                         input logic [59:0] offs, input logic [31:0] wd);
        m_psel[i]             = 1'b1;
        m_penable[i]          = 1'b0;
        m_pwrite[i]           = wr;
        m_paddr[i*62 +: 62]   = {slv, offs};
        m_pwdata[i*32 +: 32]  = wd;
    endtask

    task automatic drop_m(input int i);
        m_psel[i]    = 1'b0;
        m_penable[i] = 1'b0;
    endtask

    function automatic logic [59:0] spaddr(input int s);
        return s_paddr[s*60 +: 60];
    endfunction

    function automatic logic [31:0] spwdata(input int s);
        return s_pwdata[s*32 +: 32];
    endfunction

    function automatic logic [31:0] mprdata(input int i);
        return m_prdata[i*32 +: 32];
    endfunction

    initial begin
        preset_n  = 1'b0;
        m_psel    = '0;
        m_penable = '0;
        m_pwrite  = '0;
        m_paddr   = '0;
        m_pwdata  = '0;
        s_prdata  = '0;
        s_pslverr = '0;
        rdy_en    = 4'hF;

        // reset state
        next(); next(); mid();
        chk("rst_psel", s_psel, 0);
        chk("rst_penable", s_penable, 0);
        chk("rst_pready", m_pready, 0);
        chk("rst_prdata", {127'b0, |m_prdata}, 0);
        next(); preset_n = 1'b1; mid();

        // single write M0 -> comp 2
        next(); set_m(0, 2'd2, 1'b1, 60'h012_3456_789A_BCDE_F, 32'hDEADBEEF); mid();
        chk("wr_no_sel_yet", s_psel, 0);
        next(); m_penable[0] = 1'b1; mid();
        chk("wr_psel", s_psel, 4'b0100);
        chk("wr_setup_penable", s_penable, 0);
        chk("wr_paddr", spaddr(2), 60'h012_3456_789A_BCDE_F);
        chk("wr_pwdata", spwdata(2), 32'hDEADBEEF);
        chk("wr_pwrite", s_pwrite[2], 1);
        next(); mid();
        chk("wr_access", s_penable, 4'b0100);
        chk("wr_no_ready_yet", m_pready, 0);
        next(); mid();
        chk("wr_mready", m_pready, 3'b001);
        chk("wr_psel_off", s_psel, 0);
        chk("wr_prdata_untouched", mprdata(0), 0);
        next(); drop_m(0); mid();
        chk("wr_pulse_one_cycle", m_pready, 0);

        // single read M1 -> comp 0 with error
        s_prdata[31:0] = 32'hCAFEF00D;
        s_pslverr[0]   = 1'b1;
        next(); set_m(1, 2'd0, 1'b0, 60'h55, 32'h0); mid();
        next(); m_penable[1] = 1'b1; mid();
        chk("rd_psel", s_psel, 4'b0001);
        chk("rd_paddr", spaddr(0), 60'h55);
        chk("rd_pwrite", s_pwrite[0], 0);
        next(); mid();
        next(); mid();
        chk("rd_mready", m_pready, 3'b010);
        chk("rd_prdata", mprdata(1), 32'hCAFEF00D);
        chk("rd_pslverr", m_pslverr[1], 1);
        next(); drop_m(1); mid();
        chk("rd_prdata_hold", mprdata(1), 32'hCAFEF00D);

        // staggered contention on comp 1: M2, then M0, then M1
        rdy_en[1] = 1'b0;
        next(); set_m(2, 2'd1, 1'b1, 60'h300, 32'h3000); mid();
        next(); m_penable[2] = 1'b1; mid();
        chk("stg_first_m2", spaddr(1), 60'h300);
        next(); set_m(0, 2'd1, 1'b1, 60'h100, 32'h1000); mid();
        next(); m_penable[0] = 1'b1; mid();
        chk("stg_waiting", m_pready, 0);
        chk("stg_still_m2", spaddr(1), 60'h300);
        next(); set_m(1, 2'd1, 1'b1, 60'h200, 32'h2000); mid();
        next(); m_penable[1] = 1'b1; mid();
        next(); mid();
        next(); mid();
        next(); rdy_en[1] = 1'b1; mid();
        chk("stg_m2_access", s_penable[1], 1);
        next(); mid();
        chk("stg_m2_done", m_pready, 3'b100);
        chk("stg_m0_setup", {s_psel[1], s_penable[1]}, 2'b10);
        chk("stg_m0_addr", spaddr(1), 60'h100);
        chk("stg_m0_data", spwdata(1), 32'h1000);
        next(); drop_m(2); mid();
        chk("stg_m0_access", s_penable[1], 1);
        next(); mid();
        chk("stg_m0_done", m_pready, 3'b001);
        chk("stg_m1_addr", spaddr(1), 60'h200);
        next(); drop_m(0); mid();
        next(); mid();
        chk("stg_m1_done", m_pready, 3'b010);
        chk("stg_idle", s_psel[1], 0);
        chk("stg_wr_err_updated", m_pslverr[1], 0);
        chk("stg_wr_keeps_rdata", mprdata(1), 32'hCAFEF00D);
        next(); drop_m(1); mid();

        // simultaneous arrival on comp 3
        s_prdata[127:96] = 32'h33333333;
        next();
        set_m(0, 2'd3, 1'b0, 60'hA, 32'h0);
        set_m(1, 2'd3, 1'b0, 60'hB, 32'h0);
        set_m(2, 2'd3, 1'b0, 60'hC, 32'h0);
        mid();
        next(); m_penable = 3'b111; mid();
        chk("sim_psel", s_psel, 4'b1000);
        chk("sim_first_m0", spaddr(3), 60'hA);
        next(); mid();
        next(); mid();
        chk("sim_m0_done", m_pready, 3'b001);
        chk("sim_m0_rdata", mprdata(0), 32'h33333333);
        chk("sim_m1_addr", spaddr(3), 60'hB);
        next(); drop_m(0); mid();
        next(); mid();
        chk("sim_m1_done", m_pready, 3'b010);
        chk("sim_m2_addr", spaddr(3), 60'hC);
        next(); drop_m(1); mid();
        next(); mid();
        chk("sim_m2_done", m_pready, 3'b100);
        chk("sim_m2_rdata", mprdata(2), 32'h33333333);
        next(); drop_m(2); mid();

        // parallel transfers on comp 0 and comp 1
        s_prdata[63:32] = 32'h11111111;
        next();
        set_m(0, 2'd0, 1'b0, 60'h10, 32'h0);
        set_m(1, 2'd1, 1'b0, 60'h20, 32'h0);
        mid();
        next(); m_penable[1:0] = 2'b11; mid();
        chk("par_psel", s_psel, 4'b0011);
        next(); mid();
        chk("par_penable", s_penable, 4'b0011);
        next(); mid();
        chk("par_mready", m_pready, 3'b011);
        chk("par_rdata0", mprdata(0), 32'hCAFEF00D);
        chk("par_rdata1", mprdata(1), 32'h11111111);
        chk("par_pslverr", m_pslverr, 3'b001);
        next(); drop_m(0); drop_m(1); mid();

        // reset while comp 2 is in ACCESS with two requests queued
        rdy_en[2] = 1'b0;
        next();
        set_m(0, 2'd2, 1'b0, 60'h7, 32'h0);
        set_m(1, 2'd2, 1'b0, 60'h8, 32'h0);
        set_m(2, 2'd2, 1'b0, 60'h9, 32'h0);
        mid();
        next(); m_penable = 3'b111; mid();
        chk("mrst_psel", s_psel, 4'b0100);
        next(); mid();
        chk("mrst_access", s_penable, 4'b0100);
        next(); preset_n = 1'b0; m_psel = '0; m_penable = '0; mid();
        next(); preset_n = 1'b1; mid();
        chk("mrst_psel_clr", s_psel, 0);
        chk("mrst_penable_clr", s_penable, 0);
        chk("mrst_pready_clr", m_pready, 0);
        chk("mrst_pslverr_clr", m_pslverr, 0);
        chk("mrst_prdata_clr", {127'b0, |m_prdata}, 0);
        chk("mrst_paddr_clr", {127'b0, |s_paddr}, 0);
        chk("mrst_pwdata_clr", {127'b0, |s_pwdata}, 0);
        chk("mrst_pwrite_clr", s_pwrite, 0);
        next(); rdy_en[2] = 1'b1; mid();
        chk("mrst_queue_empty", s_psel, 0);
        chk("mrst_no_pready", m_pready, 0);
        s_prdata[95:64] = 32'h12345678;
        next(); set_m(1, 2'd2, 1'b0, 60'h42, 32'h0); mid();
        next(); m_penable[1] = 1'b1; mid();
        chk("post_psel", s_psel, 4'b0100);
        chk("post_paddr", spaddr(2), 60'h42);
        next(); mid();
        next(); mid();
        chk("post_mready", m_pready, 3'b010);
        chk("post_rdata", mprdata(1), 32'h12345678);
        next(); drop_m(1); mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/crossbar_noc.md
Name: crossbar_noc

Overview:
APB interconnect built as a full crossbar: 3 APB requester (master) ports to 4 APB completer (slave) ports. Each master transfer is routed to the slave named by the top address bits. Each slave port has its own arbiter that serves concurrent requesters in arrival order. Transfers to different slaves proceed in parallel.

Parameters:
NUM_MST, 3, number of master ports (IDs 0..2)
NUM_SLV, 4, number of slave ports (comp_id 0..3)
ADDR_W, 62, master address width; [61:60] = slave id, [59:0] = forwarded offset
DATA_W, 32, read/write data width

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset_n  in  1  synchronous active-low reset
m_psel  in  NUM_MST  per-master select
m_penable  in  NUM_MST  per-master access phase
m_pwrite  in  NUM_MST  1 = write, 0 = read
m_paddr  in  NUM_MST*ADDR_W  master addresses, master i at slice i
m_pwdata  in  NUM_MST*DATA_W  write data
m_prdata  out  NUM_MST*DATA_W  read data returned to master
m_pready  out  NUM_MST  transfer-complete strobe to master
m_pslverr  out  NUM_MST  error returned to master
s_psel  out  NUM_SLV  per-slave select
s_penable  out  NUM_SLV  per-slave access phase
s_pwrite  out  NUM_SLV  write flag to slave
s_paddr  out  NUM_SLV*60  offset address paddr[59:0]
s_pwdata  out  NUM_SLV*DATA_W  write data to slave
s_prdata  in  NUM_SLV*DATA_W  slave read data
s_pready  in  NUM_SLV  slave ready
s_pslverr  in  NUM_SLV  slave error

Behaviour:
- Reset (preset_n low at a pclk edge): all s_psel, s_penable, m_pready and m_pslverr are 0; s_pwrite, s_paddr, s_pwdata and m_prdata are 0. All arbiter queues are cleared and all slaves are IDLE. Reset mid-transfer aborts the transfer silently; no m_pready is issued for it.
- Request capture: a master request occurs on the first cycle with m_psel[i]=1 and m_penable[i]=0. Target = m_paddr[i][61:60]. The master must hold psel, addr, write and wdata stable until it sees m_pready[i].
- Per-slave FSM: IDLE -> SETUP -> ACCESS -> IDLE.
  - IDLE: if the queue is non-empty, latch the head master's request and go to SETUP. s_psel=1, s_penable=0.
  - SETUP: lasts exactly one cycle, then ACCESS with s_penable=1.
  - ACCESS: wait for s_pready. On s_pready=1, capture s_prdata and s_pslverr, deassert s_psel and s_penable, and pop the queue.
- Latency, uncontended: master setup at cycle N -> s_psel at N+1 -> s_penable at N+2 -> slave pready at cycle R >= N+2 -> m_pready[i]=1 for exactly one cycle at R+1. At R+1, m_prdata holds the read data (reads) and m_pslverr the error flag.
- m_pready stays 0 while a request waits in a queue, so the master sits in its access phase.
- Arbitration per slave: FIFO of depth NUM_MST holding master IDs, enqueued in request-cycle order.
  - Same-cycle requests are enqueued in ascending master ID (0 first).
  - A master has at most one outstanding request, so the FIFO cannot overflow.
  - Back-to-back: the next queued request enters SETUP in the cycle after the pop (IDLE is skipped); no bubble beyond that cycle.
- Different slaves operate independently and concurrently.
- Outputs m_prdata and m_pslverr hold their last values until the next completion for that master. s_paddr, s_pwdata and s_pwrite hold their values while idle.
- Writes: m_prdata is not updated.

Decomposition:
- Package crossbar_noc_pkg: NUM_MST, NUM_SLV, ADDR_W, DATA_W, SLV_ID_W=2, OFFS_W=60, MST_ID_W=2, and the slave FSM state enum {IDLE, SETUP, ACCESS}.
- One sub-module, crossbar_noc_slv_port, instantiated NUM_SLV times. It contains the arrival-order queue, the slave FSM and the response steering. The top level holds only request decode and response muxing to masters.

Test Plan:
- Single write: M0 writes to comp 2, addr offset 0x0_1234_5678_9ABC_DEF, data 0xDEADBEEF; slave pready on its first access cycle. Required: s_psel[2] one cycle after request, correct offset and data, m_pready[0] pulse 1 cycle after the slave pready.
- Single read: M1 reads comp 0, slave returns 0xCAFEF00D with pslverr=1. Required: m_prdata[1]=0xCAFEF00D, m_pslverr[1]=1, coincident with the m_pready pulse.
- Contention with staggered arrival: M2 at cycle 3, M0 at cycle 5, M1 at cycle 7, all to comp 1. Required: slave serves M2, M0, M1 in that order, back-to-back.
- Simultaneous arrival: M0, M1 and M2 all request comp 3 in the same cycle. Required: service order M0, M1, M2.
- Parallelism: M0 targets comp 0 and M1 targets comp 1 in the same cycle. Required: both slaves selected in the same cycle, both masters complete with no added latency.
- Reset mid-transfer: preset_n low while comp 2 is in ACCESS with 2 requests queued. Required: all outputs 0 at the next edge, no m_pready issued, a fresh request after reset completes normally.
